// File: rtl/seg7_pkg.sv
// Shared constants and FSM state type for the seven-segment readback capture.
// Segment patterns are active-low, bit order g..a.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_to_hex_capture_if.sv
// Segment readback bus: display-side inputs plus the capture result handshake.
// master = checker/bench side, slave = capture block.
interface seg7_to_hex_capture_if #(
    parameter int NUM_DIGITS = 8
);
    logic [7*NUM_DIGITS-1:0] i_seg;
    logic                    i_sample;
    logic                    i_ready;
    logic                    o_busy;
    logic                    o_valid;
    logic [4*NUM_DIGITS-1:0] o_value;
    logic                    o_err;
    logic [NUM_DIGITS-1:0]   o_err_mask;
    logic [NUM_DIGITS-1:0]   o_blank_mask;

    modport master (
        output i_seg, i_sample, i_ready,
        input  o_busy, o_valid, o_value, o_err, o_err_mask, o_blank_mask
    );

    modport slave (
        input  i_seg, i_sample, i_ready,
        output o_busy, o_valid, o_value, o_err, o_err_mask, o_blank_mask
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational active-low 7-segment pattern to hex nibble decoder.
// SEG7_CAPTURE_BLANK_EN: all-off pattern reports blank instead of unrecognised.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] nib,
    output logic       hit,
    output logic       blank
);

    always_comb begin
        nib   = 4'h0;
        hit   = 1'b1;
        blank = 1'b0;
        unique case (pat)
            SEG_0: nib = 4'h0;
            SEG_1: nib = 4'h1;
            SEG_2: nib = 4'h2;
            SEG_3: nib = 4'h3;
            SEG_4: nib = 4'h4;
            SEG_5: nib = 4'h5;
            SEG_6: nib = 4'h6;
            SEG_7: nib = 4'h7;
            SEG_8: nib = 4'h8;
            SEG_9: nib = 4'h9;
            SEG_A: nib = 4'hA;
            SEG_B: nib = 4'hB;
            SEG_C: nib = 4'hC;
            SEG_D: nib = 4'hD;
            SEG_E: nib = 4'hE;
            SEG_F: nib = 4'hF;
`ifdef SEG7_CAPTURE_BLANK_EN
            SEG_BLANK: begin
                hit   = 1'b0;
                blank = 1'b1;
            end
`endif
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_to_hex_capture.sv
// Scans the display segment bus digit by digit, debounces and decodes it.
// Optional SEG7_CAPTURE_BLANK_EN reports all-off digits in o_blank_mask.
module seg7_to_hex_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_WAIT      = 255
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    seg7_to_hex_capture_if.slave  bus
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;

    state_t                  state;
    state_t                  state_nxt;
    logic [IW-1:0]           idx;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nxt;
    logic [WW-1:0]           wcnt;
    logic [WW-1:0]           wcnt_nxt;
    logic [6:0]              held;
    logic [6:0]              held_nxt;
    logic [6:0]              cur;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   err_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic [3:0]              nib;
    logic                    hit;
    logic                    blank;
    logic                    restart;
    logic                    accept;
    logic                    timeout;
    logic                    advance;
    logic                    last;
    logic                    start;

    assign cur      = bus.i_seg[int'(idx)*7 +: 7];
    assign restart  = (cnt == '0) || (cur != held);
    assign held_nxt = restart ? cur : held;
    assign cnt_nxt  = restart ? CW'(1) : cnt + CW'(1);
    assign wcnt_nxt = wcnt + WW'(1);
    assign accept   = (state == SCAN) && (cnt_nxt == CW'(STABLE_CYCLES));
    assign timeout  = (state == SCAN) && !accept
                   && (wcnt_nxt == WW'(MAX_WAIT));
    assign advance  = accept || timeout;
    assign last     = (idx == IW'(NUM_DIGITS - 1));
    assign start    = (state_nxt == SCAN) && (state != SCAN);

    // Decode the value being held this cycle so single-sample acceptance works.
    seg7_decode u_dec (
        .pat   (held_nxt),
        .nib   (nib),
        .hit   (hit),
        .blank (blank)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.i_sample) state_nxt = SCAN;
            SCAN: if (advance && last) state_nxt = DONE;
            DONE: if (bus.i_ready) begin
                state_nxt = bus.i_sample ? SCAN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || start) begin
            idx     <= '0;
            cnt     <= '0;
            wcnt    <= '0;
            held    <= '0;
            value_q <= '0;
            err_q   <= '0;
            blank_q <= '0;
        end else if (state == SCAN) begin
            held <= held_nxt;
            if (advance) begin
                value_q[int'(idx)*4 +: 4] <= accept ? nib : 4'h0;
                err_q[idx]   <= !(accept && (hit || blank));
                blank_q[idx] <= accept && blank;
                idx  <= last ? idx : idx + IW'(1);
                cnt  <= '0;
                wcnt <= '0;
            end else begin
                cnt  <= cnt_nxt;
                wcnt <= wcnt_nxt;
            end
        end
    end

    assign bus.o_busy       = (state == SCAN);
    assign bus.o_valid      = (state == DONE);
    assign bus.o_value      = value_q;
    assign bus.o_err_mask   = err_q;
    assign bus.o_err        = |err_q;
`ifdef SEG7_CAPTURE_BLANK_EN
    assign bus.o_blank_mask = blank_q;
`else
    assign bus.o_blank_mask = '0;
`endif

endmodule

// File: tb/tb_seg7_to_hex_capture.sv
// Directed testbench for seg7_to_hex_capture (default parameters).
// Build with SEG7_CAPTURE_BLANK_EN defined to exercise blank reporting.
module tb_seg7_to_hex_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seg7_to_hex_capture_if #(.NUM_DIGITS(8)) bus ();

    seg7_to_hex_capture #(
        .NUM_DIGITS    (8),
        .STABLE_CYCLES (4),
        .MAX_WAIT      (255)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        logic [55:0] seg;
        logic [31:0] val;
        logic [7:0]  err;
        logic [7:0]  blank;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    function automatic logic [55:0] enc_word(input logic [31:0] w);
        logic [55:0] s;
        for (int d = 0; d < 8; d++) s[d*7 +: 7] = enc(w[d*4 +: 4]);
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts a capture and runs until o_valid; optionally toggles one digit
    // between a/b on the first nt scan edges, then holds b.
    task automatic capture(input logic [55:0] seg, input int dig,
                           input logic [6:0] a, input logic [6:0] b,
                           input int nt, output int lat);
        logic [55:0] s;
        s = seg;
        lat = 0;
        bus.i_seg = s;
        bus.i_sample = 1'b1;
        @(posedge clk);
        #1;
        bus.i_sample = 1'b0;
        check("busy_after_sample", 64'(bus.o_busy), 64'd1);
        for (int k = 1; k <= 3000; k++) begin
            if (nt > 0) begin
                s[dig*7 +: 7] = (k <= nt) ? ((k % 2 == 1) ? a : b) : b;
                bus.i_seg = s;
            end
            @(posedge clk);
            #1;
            if (bus.o_valid) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check("valid_timeout", 64'd0, 64'd1);
        check("busy_low_in_done", 64'(bus.o_busy), 64'd0);
    endtask

    task automatic ack();
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        check("valid_drop_after_ack", 64'(bus.o_valid), 64'd0);
        check("idle_after_ack", 64'(bus.o_busy), 64'd0);
    endtask

    int          lat;
    logic [31:0] w;
    logic [55:0] s;
    logic [31:0] hv;
    logic [7:0]  he;
    logic        stable_ok;

    initial begin
        bus.i_seg    = '1;
        bus.i_sample = 1'b0;
        bus.i_ready  = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 64'(bus.o_busy), 64'd0);
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_value", 64'(bus.o_value), 64'd0);
        check("rst_err", 64'(bus.o_err), 64'd0);
        check("rst_err_mask", 64'(bus.o_err_mask), 64'd0);
        check("rst_blank_mask", 64'(bus.o_blank_mask), 64'd0);

        vecs[0] = '{"nominal", enc_word(32'h1234ABCD), 32'h1234ABCD,
                    8'h00, 8'h00};
        vecs[1] = '{"low_digits", enc_word(32'h76543210), 32'h76543210,
                    8'h00, 8'h00};
        vecs[2] = '{"high_digits", enc_word(32'hFEDCBA98), 32'hFEDCBA98,
                    8'h00, 8'h00};
        s = enc_word(32'h1234ABCD);
        s[5*7 +: 7] = 7'h7F;
`ifdef SEG7_CAPTURE_BLANK_EN
        vecs[3] = '{"blank5", s, 32'h1204ABCD, 8'h00, 8'h20};
`else
        vecs[3] = '{"blank5", s, 32'h1204ABCD, 8'h20, 8'h00};
`endif
        s = enc_word(32'h89ABCDEF);
        s[3*7 +: 7] = 7'h7E;
        vecs[4] = '{"bad3", s, 32'h89AB0DEF, 8'h08, 8'h00};
        s = enc_word(32'h55555555);
        s[0 +: 7]   = 7'h55;
        s[7*7 +: 7] = 7'h01;
        vecs[5] = '{"bad0_bad7", s, 32'h05555550, 8'h81, 8'h00};

        for (int i = 0; i < 6; i++) begin
            capture(vecs[i].seg, 0, 7'h0, 7'h0, 0, lat);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'd32);
            check({vecs[i].name, "_value"}, 64'(bus.o_value),
                  64'(vecs[i].val));
            check({vecs[i].name, "_err_mask"}, 64'(bus.o_err_mask),
                  64'(vecs[i].err));
            check({vecs[i].name, "_err"}, 64'(bus.o_err),
                  64'(vecs[i].err != 8'h00));
            check({vecs[i].name, "_blank_mask"}, 64'(bus.o_blank_mask),
                  64'(vecs[i].blank));
            ack();
        end

        // Digit 2 jitters 30/19 for 10 edges; its window restarts once.
        w = 32'h1234ABCD;
        capture(enc_word(w), 2, 7'h30, 7'h19, 10, lat);
        check("jitter_latency", 64'(lat), 64'd33);
        check("jitter_value", 64'(bus.o_value), 64'h1234A4CD);
        check("jitter_err", 64'(bus.o_err), 64'd0);
        ack();

        // Digit 0 never settles and is forced through after 255 cycles.
        capture(enc_word(w), 0, 7'h40, 7'h79, 1000000, lat);
        check("timeout_latency", 64'(lat), 64'd283);
        check("timeout_value", 64'(bus.o_value), 64'h1234ABC0);
        check("timeout_err_mask", 64'(bus.o_err_mask), 64'h01);
        check("timeout_err", 64'(bus.o_err), 64'd1);

        // Outputs must hold while the consumer stalls.
        hv = bus.o_value;
        he = bus.o_err_mask;
        stable_ok = 1'b1;
        bus.i_seg = enc_word(32'h0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (!bus.o_valid || bus.o_value !== hv || bus.o_err_mask !== he)
                stable_ok = 1'b0;
        end
        check("hold_while_stalled", 64'(stable_ok), 64'd1);

        // Back-to-back restart.
        bus.i_seg = enc_word(32'hCAFE0123);
        bus.i_ready = 1'b1;
        bus.i_sample = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        bus.i_sample = 1'b0;
        check("restart_valid", 64'(bus.o_valid), 64'd0);
        check("restart_busy", 64'(bus.o_busy), 64'd1);
        check("restart_cleared", 64'(bus.o_err_mask), 64'd0);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) begin
                lat = k;
                break;
            end
        end
        check("restart_latency", 64'(lat), 64'd32);
        check("restart_value", 64'(bus.o_value), 64'hCAFE0123);
        ack();

        // Reset mid-scan aborts without presenting a result.
        bus.i_sample = 1'b1;
        @(posedge clk);
        #1;
        bus.i_sample = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 64'(bus.o_busy), 64'd0);
        check("abort_value", 64'(bus.o_value), 64'd0);
        stable_ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid || bus.o_busy) stable_ok = 1'b0;
        end
        check("abort_no_result", 64'(stable_ok), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
